// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter state encoding, command bytes and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  localparam int PS2_CLK_HZ_DEF      = 100_000_000;
  localparam int PS2_INHIBIT_US      = 100;
  localparam int PS2_INHIBIT_CYC_DEF = 10_000;
  localparam int PS2_FILT_CYC_DEF    = 8;
  localparam int PS2_TIMEOUT_CYC_DEF = 1_500_000;

  function automatic int ps2_us_to_cyc(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// One PS/2 line: 2-FF synchroniser, stability filter and falling-edge pulse.
// Shareable with the receiver; the filter suppresses slow-edge ringing on the open-drain bus.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int FILT_CYC = PS2_FILT_CYC_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam logic [CW-1:0] FILT_LOAD = CW'(FILT_CYC - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // A new level is accepted only after it has differed from the current one for FILT_CYC cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= FILT_LOAD;
    end else begin
      r_s1   <= i_line;
      r_s2   <= r_s1;
      r_fall <= 1'b0;
      if (r_s2 == r_level) begin
        r_cnt <= FILT_LOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_s2;
        r_fall  <= ~r_s2;
        r_cnt   <= FILT_LOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift, line ACK check.
// Build option PS2_TX_TIMEOUT_EN adds a watchdog that aborts a stalled transfer with err.
//
//  state      | meaning
//  IDLE       | lines released, tx_ready high
//  INHIBIT    | clock held low; data pulled low in the last cycle
//  RTS        | clock released, start bit (data low) presented, wait for device clock
//  SHIFT      | present data bits, parity, stop on successive device falls
//  ACK        | sample device ACK on the 11th fall
//  WAIT_IDLE  | wait for both lines back high
//  DONE       | one-cycle done pulse with ack_ok / err
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = PS2_CLK_HZ_DEF,
  parameter int INHIBIT_CYC = ps2_us_to_cyc(CLK_HZ, PS2_INHIBIT_US),
  parameter int FILT_CYC    = PS2_FILT_CYC_DEF
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
`endif
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_ok,
  output logic       o_err,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe
);

  localparam int TW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYC - 1);

  ps2_tx_state_e r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_parity, w_parity_nxt;
  logic [3:0]    r_edge_cnt, w_edge_nxt;
  logic          r_ack_ok, w_ack_nxt;
  logic          r_clk_oe, w_clk_oe_nxt;
  logic          r_data_oe, w_data_oe_nxt;
  logic          r_ready_en;
  logic          w_tx_ready;
  logic          w_clk_lvl, w_clk_fall;
  logic          w_data_lvl, w_data_fall;

  ps2_line_sync #(.FILT_CYC(FILT_CYC)) u_clk_sync (
    .clk     (clk),
    .rstn    (rstn),
    .i_line  (i_ps2_clk),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_line_sync #(.FILT_CYC(FILT_CYC)) u_data_sync (
    .clk     (clk),
    .rstn    (rstn),
    .i_line  (i_ps2_data),
    .o_level (w_data_lvl),
    .o_fall  (w_data_fall)
  );

  assign w_tx_ready = (r_state == ST_IDLE) && r_ready_en;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [23:0] WDOG_LOAD = 24'(TIMEOUT_CYC - 1);
  logic [23:0] r_wdog;
  logic        w_in_wdog;

  assign w_in_wdog = (r_state == ST_RTS) || (r_state == ST_SHIFT) ||
                     (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdog <= '0;
    end else if (r_state == ST_INHIBIT && r_timer == '0) begin
      r_wdog <= WDOG_LOAD;
    end else if (w_in_wdog && r_wdog != '0) begin
      r_wdog <= r_wdog - 24'd1;
    end
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_data_nxt    = r_data;
    w_parity_nxt  = r_parity;
    w_edge_nxt    = r_edge_cnt;
    w_ack_nxt     = r_ack_ok;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    case (r_state)
      ST_IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (i_tx_valid && w_tx_ready) begin
          w_data_nxt   = i_tx_data;
          w_parity_nxt = ps2_odd_parity(i_tx_data);
          w_edge_nxt   = 4'd0;
          w_ack_nxt    = 1'b0;
          w_timer_nxt  = INH_LOAD;
          w_clk_oe_nxt = 1'b1;
          w_state_nxt  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_timer == '0) begin
          w_clk_oe_nxt = 1'b0;
          w_state_nxt  = ST_RTS;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
          if (r_timer == TW'(1)) w_data_oe_nxt = 1'b1;
        end
      end
      ST_RTS: begin
        if (w_clk_fall) begin
          w_edge_nxt    = 4'd1;
          w_data_oe_nxt = ~r_data[0];
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_clk_fall) begin
          w_edge_nxt = r_edge_cnt + 4'd1;
          if (r_edge_cnt < 4'd8) begin
            w_data_oe_nxt = ~r_data[r_edge_cnt[2:0]];
          end else if (r_edge_cnt == 4'd8) begin
            w_data_oe_nxt = ~r_parity;
          end else begin
            w_data_oe_nxt = 1'b0;
            w_state_nxt   = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (w_clk_fall) begin
          w_edge_nxt  = 4'd11;
          w_ack_nxt   = ~w_data_lvl;
          w_state_nxt = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_clk_lvl && w_data_lvl) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
      default: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (w_in_wdog && r_wdog == '0) begin
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = 1'b0;
      w_ack_nxt     = 1'b0;
      w_state_nxt   = ST_DONE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_data     <= '0;
      r_parity   <= 1'b0;
      r_edge_cnt <= '0;
      r_ack_ok   <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_data     <= w_data_nxt;
      r_parity   <= w_parity_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_ack_ok   <= w_ack_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_ready_en <= 1'b1;
    end
  end

  // Data-line falls carry no meaning for the host side; only the level is sampled at ACK.
  logic w_unused;
  assign w_unused = w_data_fall;

  assign o_tx_ready    = w_tx_ready;
  assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done        = (r_state == ST_DONE);
  assign o_ack_ok      = (r_state == ST_DONE) && r_ack_ok;
  assign o_err         = (r_state == ST_DONE) && !r_ack_ok;
  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;

endmodule
